sisc_mc_ctrl: RTL and testbench

Parametrised multi-cycle control unit for the next-generation SISC core. It replaces the fixed-latency controller with a state machine that waits on `imem_ready`/`dmem_ready` handshakes and times out stalled memory. It adds load/store and halt sequencing and keeps a retired-instruction counter. It sits between the IR/status register and the pc, ir, rf, alu, mux and data-memory strobes of the top level.

---
 rtl/sisc_pkg.sv | 28 ++
 rtl/sisc_wait_timer.sv | 28 ++
 rtl/sisc_mc_ctrl.sv | 164 ++++++++++++++++
 tb/tb_sisc_mc_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/sisc_pkg.sv
// Shared encodings for the SISC multi-cycle controller: opcodes, ALU ops, FSM states.
package sisc_pkg;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_ALU_RR = 4'h1;
  localparam logic [3:0] OP_ALU_IM = 4'h2;
  localparam logic [3:0] OP_LOD    = 4'h3;
  localparam logic [3:0] OP_STR    = 4'h4;
  localparam logic [3:0] OP_BRA    = 4'h5;
  localparam logic [3:0] OP_BRR    = 4'h6;
  localparam logic [3:0] OP_HLT    = 4'hF;

  localparam logic [1:0] ALU_IDLE = 2'b00;
  localparam logic [1:0] ALU_RR   = 2'b01;
  localparam logic [1:0] ALU_IMM  = 2'b10;
  localparam logic [1:0] ALU_ADDR = 2'b11;

  typedef enum logic [2:0] {
    ST_START, ST_FETCH, ST_DECODE, ST_EXECUTE,
    ST_MEM, ST_WRITEBACK, ST_HALT, ST_FAULT
  } state_t;

  // A zero mask means unconditional.
  function automatic logic br_taken(input logic [3:0] mm, input logic [3:0] stat);
    return (mm == 4'h0) || ((stat & mm) != 4'h0);
  endfunction

endpackage

// File: rtl/sisc_wait_timer.sv
// Counts stalled memory cycles; flags the cycle in which one more stall would reach WAIT_MAX.
module sisc_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst_f,
  input  logic clr,
  input  logic busy,
  output logic expired
);

  localparam int W = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [W-1:0] CNT_MAX  = W'(WAIT_MAX);
  localparam logic [W-1:0] CNT_LAST = (WAIT_MAX > 0) ? W'(WAIT_MAX - 1) : '0;

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_f || clr)
      r_cnt <= '0;
    else if (busy && (r_cnt != CNT_MAX))
      r_cnt <= r_cnt + 1'b1;
  end

  // Ready in the final allowed cycle clears busy, so it beats the timeout.
  assign expired = (WAIT_MAX != 0) && busy && (r_cnt == CNT_LAST);

endmodule

// File: rtl/sisc_mc_ctrl.sv
// Multi-cycle SISC control FSM with memory handshakes, wait timeout, halt/fault and retire counter.
module sisc_mc_ctrl
  import sisc_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_f,
  input  logic [3:0]       opcode,
  input  logic [3:0]       mm,
  input  logic [3:0]       stat,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             pc_rst,
  output logic             pc_write,
  output logic             pc_sel,
  output logic             br_sel,
  output logic             ir_load,
  output logic             imem_req,
  output logic             rf_we,
  output logic             wb_sel,
  output logic             rd_sel,
  output logic [1:0]       alu_op,
  output logic             stat_en,
  output logic             dmem_rd,
  output logic             dmem_wr,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] instret
);

  state_t r_state, w_nxt;
  logic   w_retire, w_busy, w_expired, w_clr;
  logic   w_is_lod;

  assign w_is_lod = (opcode == OP_LOD);
  assign w_busy   = ((r_state == ST_FETCH) && !imem_ready) ||
                    ((r_state == ST_MEM)   && !dmem_ready);
  assign w_clr    = (w_nxt != r_state);

  sisc_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
    .clk     (clk),
    .rst_f   (rst_f),
    .clr     (w_clr),
    .busy    (w_busy),
    .expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_f) begin
      r_state <= ST_START;
      instret <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_retire) instret <= instret + 1'b1;
    end
  end

  always_comb begin
    w_nxt    = r_state;
    w_retire = 1'b0;
    pc_rst   = 1'b0;
    pc_write = 1'b0;
    pc_sel   = 1'b0;
    br_sel   = 1'b0;
    ir_load  = 1'b0;
    imem_req = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = 1'b0;
    rd_sel   = 1'b0;
    alu_op   = ALU_IDLE;
    stat_en  = 1'b0;
    dmem_rd  = 1'b0;
    dmem_wr  = 1'b0;
    halted   = 1'b0;
    fault    = 1'b0;
    case (r_state)
      ST_START: begin
        pc_rst = 1'b1;
        w_nxt  = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_load  = 1'b1;
          pc_write = 1'b1;
          w_nxt    = ST_DECODE;
        end else if (w_expired) begin
          w_nxt = ST_FAULT;
        end
      end
      ST_DECODE: begin
        case (opcode)
          OP_NOP: begin
            w_retire = 1'b1;
            w_nxt    = ST_FETCH;
          end
          OP_BRA, OP_BRR: begin
            if (br_taken(mm, stat)) begin
              pc_write = 1'b1;
              pc_sel   = 1'b1;
              br_sel   = (opcode == OP_BRR);
            end
            w_retire = 1'b1;
            w_nxt    = ST_FETCH;
          end
          OP_HLT: begin
            w_retire = 1'b1;
            w_nxt    = ST_HALT;
          end
          OP_ALU_RR, OP_ALU_IM, OP_LOD, OP_STR: w_nxt = ST_EXECUTE;
          default: w_nxt = ST_FAULT;
        endcase
      end
      ST_EXECUTE: begin
        if (w_is_lod || opcode == OP_STR) begin
          alu_op = ALU_ADDR;
          w_nxt  = ST_MEM;
        end else begin
          alu_op  = (opcode == OP_ALU_RR) ? ALU_RR : ALU_IMM;
          stat_en = 1'b1;
          w_nxt   = ST_WRITEBACK;
        end
      end
      ST_MEM: begin
        dmem_rd = w_is_lod;
        dmem_wr = !w_is_lod;
        if (dmem_ready) begin
          if (w_is_lod) begin
            w_nxt = ST_WRITEBACK;
          end else begin
            w_retire = 1'b1;
            w_nxt    = ST_FETCH;
          end
        end else if (w_expired) begin
          w_nxt = ST_FAULT;
        end
      end
      ST_WRITEBACK: begin
        rf_we    = 1'b1;
        wb_sel   = !w_is_lod;
        rd_sel   = (opcode != OP_ALU_RR);
        w_retire = 1'b1;
        w_nxt    = ST_FETCH;
      end
      ST_HALT:  halted = 1'b1;
      ST_FAULT: fault  = 1'b1;
    endcase
    // Reset masks every strobe immediately, before the next edge lands.
    if (!rst_f) begin
      pc_rst   = 1'b1;
      pc_write = 1'b0;
      ir_load  = 1'b0;
      imem_req = 1'b0;
      rf_we    = 1'b0;
      stat_en  = 1'b0;
      dmem_rd  = 1'b0;
      dmem_wr  = 1'b0;
      w_retire = 1'b0;
    end
  end

endmodule

// File: tb/tb_sisc_mc_ctrl.sv
// Directed bench for sisc_mc_ctrl: per-instruction latency/retire scoreboard plus strobe checks.
module tb_sisc_mc_ctrl;
  import sisc_pkg::*;

  logic       clk = 1'b0;
  logic       rst_f = 1'b0;
  logic [3:0] opcode = '0, mm = '0, stat = '0;
  logic       imem_ready = 1'b0, dmem_ready = 1'b0;
  logic       pc_rst, pc_write, pc_sel, br_sel, ir_load, imem_req, rf_we;
  logic       wb_sel, rd_sel, stat_en, dmem_rd, dmem_wr, halted, fault;
  logic [1:0] alu_op;
  logic [3:0] instret;
  logic [6:0] w_strb;

  always #5 clk = ~clk;

  sisc_mc_ctrl #(.WAIT_MAX(3), .CNT_W(4)) dut (
    .clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm), .stat(stat),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .pc_rst(pc_rst), .pc_write(pc_write), .pc_sel(pc_sel), .br_sel(br_sel),
    .ir_load(ir_load), .imem_req(imem_req), .rf_we(rf_we), .wb_sel(wb_sel),
    .rd_sel(rd_sel), .alu_op(alu_op), .stat_en(stat_en), .dmem_rd(dmem_rd),
    .dmem_wr(dmem_wr), .halted(halted), .fault(fault), .instret(instret)
  );

  assign w_strb = {pc_write, ir_load, imem_req, rf_we, stat_en, dmem_rd, dmem_wr};

  typedef struct {
    int         cyc;
    logic [3:0] ir;
    logic       h;
    logic       f;
  } exp_t;

  exp_t       sb[$];
  int         n_assert = 0, n_fail = 0;
  logic [3:0] exp_ir = '0;
  logic       dec_pcw, dec_pcsel, dec_brsel, wb_s, rd_s;
  logic [1:0] alu_s;
  int         dstb_n, stat_en_n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered and left just after a rising edge.
  task automatic do_reset(input int n);
    rst_f = 1'b0;
    #1;
    chk("rst_strobes", {25'd0, w_strb}, 32'd0);
    chk("rst_pc_rst", {31'd0, pc_rst}, 32'd1);
    repeat (n) @(posedge clk);
    #1;
    rst_f = 1'b1;
    #1;
    exp_ir = '0;
    chk("rst_instret", {28'd0, instret}, 32'd0);
    chk("start_pc_rst", {31'd0, pc_rst}, 32'd1);
    chk("start_no_req", {31'd0, imem_req}, 32'd0);
    @(posedge clk);
    #1;
    chk("fetch_after_start", {31'd0, imem_req}, 32'd1);
  endtask

  task automatic cyc_step(input logic ir, input logic dr);
    @(negedge clk);
    imem_ready = ir;
    dmem_ready = dr;
    @(posedge clk);
    #1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
  endtask

  // Runs one instruction starting in FETCH; iw/dw are stall cycles before ready.
  task automatic run(input string tag, input logic [3:0] op, input logic [3:0] mmv,
                     input logic [3:0] stv, input int iw, input int dw, input int ecyc,
                     input bit er, input logic eh, input logic ef);
    exp_t e;
    int   cyc = 0, icnt = 0, dcnt = 0, fat = -1;
    bit   done = 0;
    if (er) exp_ir = exp_ir + 4'd1;
    sb.push_back('{ecyc, exp_ir, eh, ef});
    dec_pcw = 0; dec_pcsel = 0; dec_brsel = 0; wb_s = 1'bx; rd_s = 1'bx;
    alu_s = ALU_IDLE; dstb_n = 0; stat_en_n = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      if (fat >= 0 && cyc == fat + 1) begin
        dec_pcw = pc_write; dec_pcsel = pc_sel; dec_brsel = br_sel;
      end
      if (imem_req) begin
        imem_ready = (icnt >= iw);
        if (imem_ready) fat = cyc;
        icnt++;
      end
      if (dmem_rd || dmem_wr) begin
        dstb_n++;
        dmem_ready = (dcnt >= dw);
        dcnt++;
      end
      if (rf_we) begin wb_s = wb_sel; rd_s = rd_sel; end
      if (alu_op != ALU_IDLE) alu_s = alu_op;
      if (stat_en) stat_en_n++;
      cyc++;
      @(posedge clk);
      #1;
      if (imem_ready) begin opcode = op; mm = mmv; stat = stv; end
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      done = halted || fault || (fat >= 0 && imem_req);
    end
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    e = sb.pop_front();
    chk({tag, "_cycles"}, cyc, e.cyc);
    chk({tag, "_instret"}, {28'd0, instret}, {28'd0, e.ir});
    chk({tag, "_halted"}, {31'd0, halted}, {31'd0, e.h});
    chk({tag, "_fault"}, {31'd0, fault}, {31'd0, e.f});
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset(3);

    // Zero-wait program.
    run("nop", OP_NOP, 4'h0, 4'h0, 0, 0, 2, 1, 0, 0);
    run("alurr", OP_ALU_RR, 4'h0, 4'h0, 0, 0, 4, 1, 0, 0);
    chk("alurr_op", alu_s, ALU_RR);
    chk("alurr_stat_en", stat_en_n, 1);
    chk("alurr_wb_rd", {wb_s, rd_s}, 2'b10);
    run("lod", OP_LOD, 4'h0, 4'h0, 0, 0, 5, 1, 0, 0);
    chk("lod_op", alu_s, ALU_ADDR);
    chk("lod_wb_rd", {wb_s, rd_s}, 2'b01);
    run("str", OP_STR, 4'h0, 4'h0, 0, 0, 4, 1, 0, 0);
    chk("str_strobes", dstb_n, 1);
    chk("str_no_stat", stat_en_n, 0);
    run("hlt", OP_HLT, 4'h0, 4'h0, 0, 0, 2, 1, 1, 0);
    repeat (3) cyc_step(1'b1, 1'b1);
    chk("halt_sticky", {31'd0, halted}, 32'd1);
    chk("halt_strobes", {25'd0, w_strb}, 32'd0);
    chk("halt_instret", {28'd0, instret}, 32'd5);

    do_reset(2);
    run("aluim", OP_ALU_IM, 4'h0, 4'h0, 0, 0, 4, 1, 0, 0);
    chk("aluim_op", alu_s, ALU_IMM);
    chk("aluim_wb_rd", {wb_s, rd_s}, 2'b11);
    run("brr_t", OP_BRR, 4'h1, 4'h1, 0, 0, 2, 1, 0, 0);
    chk("brr_t_dec", {dec_pcw, dec_pcsel, dec_brsel}, 3'b111);
    run("brr_nt", OP_BRR, 4'h1, 4'h0, 0, 0, 2, 1, 0, 0);
    chk("brr_nt_dec", {31'd0, dec_pcw}, 32'd0);
    run("bra", OP_BRA, 4'h0, 4'h0, 0, 0, 2, 1, 0, 0);
    chk("bra_dec", {dec_pcw, dec_pcsel, dec_brsel}, 3'b110);
    run("lod_w2", OP_LOD, 4'h0, 4'h0, 0, 2, 7, 1, 0, 0);
    chk("lod_w2_rd_cycles", dstb_n, 3);
    chk("lod_w2_wb_rd", {wb_s, rd_s}, 2'b01);
    run("nop_iw2", OP_NOP, 4'h0, 4'h0, 2, 0, 4, 1, 0, 0);

    // Reset landing in WRITEBACK abandons the ALU op.
    opcode = OP_ALU_RR;
    cyc_step(1'b1, 1'b0);
    cyc_step(1'b0, 1'b0);
    cyc_step(1'b0, 1'b0);
    chk("wb_rf_we", {31'd0, rf_we}, 32'd1);
    do_reset(3);

    run("ifetch_to", OP_NOP, 4'h0, 4'h0, 3, 0, 3, 0, 0, 1);
    chk("ifetch_to_req", {31'd0, imem_req}, 32'd0);
    do_reset(1);
    run("dmem_to", OP_STR, 4'h0, 4'h0, 0, 3, 6, 0, 0, 1);
    chk("dmem_to_wr", {31'd0, dmem_wr}, 32'd0);
    do_reset(1);
    run("illegal", 4'h7, 4'h0, 4'h0, 0, 0, 2, 0, 0, 1);
    do_reset(1);

    for (int i = 0; i < 17; i++) run("nop_wrap", OP_NOP, 4'h0, 4'h0, 0, 0, 2, 1, 0, 0);
    chk("instret_wrap", {28'd0, instret}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
